// File: rtl/maze_game.sv
// Grid adventure game: walls, sword, dragon, exit and a move budget on a ROWS x COLS map.
// Sticky d/win outputs plus position, inventory, move count, bump and death-cause observability.
module maze_game #(
  parameter int ROWS      = 4,
  parameter int COLS      = 4,
  parameter int START_R   = 0,
  parameter int START_C   = 0,
  parameter int SWORD_R   = 3,
  parameter int SWORD_C   = 0,
  parameter int DRAGON_R  = 2,
  parameter int DRAGON_C  = 2,
  parameter int EXIT_R    = 3,
  parameter int EXIT_C    = 3,
  parameter logic [ROWS*COLS-1:0] WALL_MAP = 16'h0040,
  parameter int MAX_MOVES = 20,
  localparam int unsigned RW = (ROWS > 2) ? $clog2(ROWS) : 1,
  localparam int unsigned CW = (COLS > 2) ? $clog2(COLS) : 1,
  localparam int unsigned MW = $clog2(MAX_MOVES + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          n,
  input  logic          s,
  input  logic          e,
  input  logic          w,
  output logic          d,
  output logic          win,
  output logic [1:0]    cause,
  output logic [RW-1:0] row,
  output logic [CW-1:0] col,
  output logic          sword,
  output logic          slain,
  output logic          bump,
  output logic [MW-1:0] moves
);

  localparam logic [1:0] PLAY = 2'd0;
  localparam logic [1:0] DEAD = 2'd1;
  localparam logic [1:0] WON  = 2'd2;

  localparam logic [1:0] CAUSE_NONE    = 2'd0;
  localparam logic [1:0] CAUSE_DRAGON  = 2'd1;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'd2;

  // Special cells must be open and pairwise distinct.
  if (ROWS < 2 || COLS < 2 || MAX_MOVES < 1 ||
      WALL_MAP[START_R*COLS+START_C] || WALL_MAP[SWORD_R*COLS+SWORD_C] ||
      WALL_MAP[DRAGON_R*COLS+DRAGON_C] || WALL_MAP[EXIT_R*COLS+EXIT_C] ||
      (START_R == SWORD_R && START_C == SWORD_C) ||
      (START_R == DRAGON_R && START_C == DRAGON_C) ||
      (START_R == EXIT_R && START_C == EXIT_C) ||
      (SWORD_R == DRAGON_R && SWORD_C == DRAGON_C) ||
      (SWORD_R == EXIT_R && SWORD_C == EXIT_C) ||
      (DRAGON_R == EXIT_R && DRAGON_C == EXIT_C)) begin : g_bad_cfg
    $error("maze_game: invalid grid configuration");
  end

  logic [1:0]    state_q, state_d;
  logic [RW-1:0] row_q, row_d;
  logic [CW-1:0] col_q, col_d;
  logic [MW-1:0] moves_q, moves_d;
  logic [1:0]    cause_q, cause_d;
  logic          sword_q, sword_d;
  logic          slain_q, slain_d;
  logic          bump_q, bump_d;
  logic          d_q, d_d;
  logic          win_q, win_d;

  int   req_cnt;
  int   tr, tc, idx;
  logic off_grid, blocked, hit_dragon, hit_exit;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= PLAY;
      row_q   <= RW'(START_R);
      col_q   <= CW'(START_C);
      moves_q <= '0;
      cause_q <= CAUSE_NONE;
      sword_q <= 1'b0;
      slain_q <= 1'b0;
      bump_q  <= 1'b0;
      d_q     <= 1'b0;
      win_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      moves_q <= moves_d;
      cause_q <= cause_d;
      sword_q <= sword_d;
      slain_q <= slain_d;
      bump_q  <= bump_d;
      d_q     <= d_d;
      win_q   <= win_d;
    end
  end

  // Classify the request, attempt the move, then resolve the entered cell and budget.
  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    col_d      = col_q;
    moves_d    = moves_q;
    cause_d    = cause_q;
    sword_d    = sword_q;
    slain_d    = slain_q;
    bump_d     = 1'b0;
    req_cnt    = $countones({n, s, e, w});
    tr         = int'(row_q) + (s ? 1 : 0) - (n ? 1 : 0);
    tc         = int'(col_q) + (e ? 1 : 0) - (w ? 1 : 0);
    off_grid   = (tr < 0) || (tr >= ROWS) || (tc < 0) || (tc >= COLS);
    idx        = off_grid ? 0 : tr * COLS + tc;
    blocked    = !off_grid && WALL_MAP[idx];
    hit_dragon = 1'b0;
    hit_exit   = 1'b0;

    if (state_q == PLAY) begin
      if (req_cnt > 1) begin
        bump_d = 1'b1;
      end else if (req_cnt == 1) begin
        moves_d = MW'(moves_q + 1'b1);
        if (off_grid || blocked) begin
          bump_d = 1'b1;
        end else begin
          row_d = RW'(tr);
          col_d = CW'(tc);
          if (tr == SWORD_R && tc == SWORD_C) sword_d = 1'b1;
          if (tr == DRAGON_R && tc == DRAGON_C && !slain_q) begin
            if (sword_q) slain_d = 1'b1;
            else         hit_dragon = 1'b1;
          end
          hit_exit = (tr == EXIT_R) && (tc == EXIT_C);
        end
        if (hit_exit) begin
          state_d = WON;
        end else if (hit_dragon) begin
          state_d = DEAD;
          cause_d = CAUSE_DRAGON;
        end else if (moves_d == MW'(MAX_MOVES)) begin
          state_d = DEAD;
          cause_d = CAUSE_TIMEOUT;
        end
      end
    end

    d_d   = (state_d == DEAD);
    win_d = (state_d == WON);
  end

  assign d     = d_q;
  assign win   = win_q;
  assign cause = cause_q;
  assign row   = row_q;
  assign col   = col_q;
  assign sword = sword_q;
  assign slain = slain_q;
  assign bump  = bump_q;
  assign moves = moves_q;

endmodule

// File: tb/tb_maze_game.sv
// Scoreboard bench for maze_game: directed scenarios plus random play against a grid-level model.
module tb_maze_game;

  localparam int ROWS = 4;
  localparam int COLS = 4;
  localparam int MAXM = 20;

  typedef struct packed {
    logic [1:0] row;
    logic [1:0] col;
    logic       d;
    logic       win;
    logic [1:0] cause;
    logic       sword;
    logic       slain;
    logic       bump;
    logic [4:0] moves;
  } obs_t;

  logic       clk = 1'b0;
  logic       reset, n, s, e, w;
  logic       d, win, sword, slain, bump;
  logic [1:0] cause, row, col;
  logic [4:0] moves;

  maze_game dut (
    .clk(clk), .reset(reset), .n(n), .s(s), .e(e), .w(w),
    .d(d), .win(win), .cause(cause), .row(row), .col(col),
    .sword(sword), .slain(slain), .bump(bump), .moves(moves)
  );

  always #5 clk = ~clk;

  obs_t sbq[$];
  int   tests = 0;
  int   fails = 0;

  // Reference model state, in grid coordinates.
  logic [15:0] wall_bits = 16'h0040;
  bit   wall[ROWS][COLS];
  int   m_r, m_c, m_moves, m_cause;
  bit   m_sword, m_slain, m_dead, m_win, m_bump;

  function automatic obs_t model_obs();
    obs_t o;
    o.row = 2'(m_r); o.col = 2'(m_c); o.d = m_dead; o.win = m_win;
    o.cause = 2'(m_cause); o.sword = m_sword; o.slain = m_slain;
    o.bump = m_bump; o.moves = 5'(m_moves);
    return o;
  endfunction

  task automatic model_step(input bit r, input bit [3:0] req);
    int cnt, nr, nc;
    cnt = $countones(req);
    if (r) begin
      m_r = 0; m_c = 0; m_moves = 0; m_cause = 0;
      m_sword = 0; m_slain = 0; m_dead = 0; m_win = 0; m_bump = 0;
    end else if (m_dead || m_win) begin
      m_bump = 0;
    end else if (cnt == 0) begin
      m_bump = 0;
    end else if (cnt > 1) begin
      m_bump = 1;
    end else begin
      m_moves++;
      nr = m_r; nc = m_c;
      if (req[3]) nr--;
      if (req[2]) nr++;
      if (req[1]) nc++;
      if (req[0]) nc--;
      if (nr < 0 || nr >= ROWS || nc < 0 || nc >= COLS || wall[nr][nc]) begin
        m_bump = 1;
      end else begin
        m_bump = 0;
        m_r = nr; m_c = nc;
        if (nr == 3 && nc == 0) m_sword = 1;
        if (nr == 2 && nc == 2 && !m_slain) begin
          if (m_sword) m_slain = 1;
          else begin m_dead = 1; m_cause = 1; end
        end
        if (nr == 3 && nc == 3) m_win = 1;
      end
      if (!m_win && !m_dead && m_moves == MAXM) begin
        m_dead = 1; m_cause = 2;
      end
    end
  endtask

  // Drive one edge's worth of stimulus and queue the response it must produce.
  task automatic step(input bit r, input bit [3:0] req);
    reset = r;
    {n, s, e, w} = req;
    model_step(r, req);
    sbq.push_back(model_obs());
    @(negedge clk);
  endtask

  task automatic run_seq(input string str);
    for (int i = 0; i < str.len(); i++) begin
      case (str[i])
        "N": step(1'b0, 4'b1000);
        "S": step(1'b0, 4'b0100);
        "E": step(1'b0, 4'b0010);
        "W": step(1'b0, 4'b0001);
        "X": step(1'b0, 4'b1010);
        "R": step(1'b1, 4'b0000);
        default: step(1'b0, 4'b0000);
      endcase
    end
  endtask

  // Monitor: every edge the DUT presents a fresh observation.
  initial begin
    obs_t exp_o, act_o;
    forever begin
      @(posedge clk);
      #1;
      if (sbq.size() > 0) begin
        exp_o = sbq.pop_front();
        act_o = '{row: row, col: col, d: d, win: win, cause: cause,
                  sword: sword, slain: slain, bump: bump, moves: moves};
        tests++;
        if (act_o !== exp_o)begin
          fails++;
          $display("FAIL obs%0d got rc=(%0d,%0d) d=%b win=%b cause=%0d sword=%b slain=%b bump=%b moves=%0d, need rc=(%0d,%0d) d=%b win=%b cause=%0d sword=%b slain=%b bump=%b moves=%0d",
                   tests, act_o.row, act_o.col, act_o.d, act_o.win, act_o.cause, act_o.sword,
                   act_o.slain, act_o.bump, act_o.moves, exp_o.row, exp_o.col, exp_o.d,
                   exp_o.win, exp_o.cause, exp_o.sword, exp_o.slain, exp_o.bump, exp_o.moves);
        end
      end
    end
  end

  initial begin
    bit [3:0] req;
    int a, b;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        wall[r][c] = wall_bits[r*COLS+c];

    run_seq("RRRRR");
    run_seq("NESEX..RR");
    run_seq("SSEESW.RR");
    run_seq("SSSNEESEN.RR");
    run_seq("NNNNNNNNNNNNNNNNNNNNNS.RR");
    run_seq("SSRSSS.RR");

    for (int i = 0; i < 3000; i++) begin
      if (((m_dead || m_win) && $urandom_range(3) == 0) || $urandom_range(79) == 0) begin
        step(1'b1, 4'b0000);
      end else begin
        a = $urandom_range(9);
        if (a < 6) begin
          req = 4'(1 << $urandom_range(3));
        end else if (a < 8) begin
          req = 4'b0000;
        end else begin
          a = $urandom_range(3);
          b = (a + 1 + $urandom_range(2)) % 4;
          req = 4'((1 << a) | (1 << b)) | 4'($urandom_range(15) & $urandom_range(15));
        end
        step(1'b0, req);
      end
    end

    for (int k = 0; k < 10 && sbq.size() > 0; k++) @(negedge clk);
    if (sbq.size() > 0) begin
      fails++;
      $display("FAIL drain got %0d pending, need 0", sbq.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/maze_game.md
# maze_game

Parametrised successor of the four-direction adventure game FSM. It plays on a ROWS×COLS grid of rooms, with compile-time walls, a sword, a dragon, an exit and a move budget. It consumes the same one-hot n/s/e/w stimulus and drives the same sticky d (death) and win outputs, so it drops into the existing GameIf-based bench. It adds position, inventory, move-count, bump and death-cause observability.

## Interface
- ROWS, 4, grid rows (≥2); row 0 is north.
- COLS, 4, grid columns (≥2); col 0 is west.
- START_R / START_C, 0 / 0, start cell.
- SWORD_R / SWORD_C, 3 / 0, sword cell.
- DRAGON_R / DRAGON_C, 2 / 2, dragon cell.
- EXIT_R / EXIT_C, 3 / 3, exit cell.
- WALL_MAP, 16'h0040, ROWS*COLS bits; bit (r*COLS+c)=1 marks a blocked cell. Start, sword, dragon and exit must be unblocked and pairwise distinct; this is checked by elaboration assertion.
- MAX_MOVES, 20, move budget (≥1).
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- n, s, e, w  in  1 each  direction requests, sampled every rising edge.
- d  out  1  game lost (sticky).
- win  out  1  game won (sticky).
- cause  out  2  0 none, 1 dragon, 2 timeout.
- row  out  RW=max(1,$clog2(ROWS))  current row.
- col  out  CW=max(1,$clog2(COLS))  current column.
- sword  out  1  sword held.
- slain  out  1  dragon killed.
- bump  out  1  one-cycle pulse: the last sampled request was rejected.
- moves  out  MW=$clog2(MAX_MOVES+1)  count of counted attempts.

## Operation
- FSM states: PLAY, DEAD, WON. Reset enters PLAY. DEAD and WON are absorbing until reset.
- In PLAY, each edge classifies {n,s,e,w}:
  - All zero: idle. Nothing changes; bump=0.
  - Two or more asserted: illegal. No move, moves unchanged, bump=1.
  - Exactly one asserted: attempt. moves increments. The target is row-1 (n), row+1 (s), col+1 (e) or col-1 (w).
    - Off-grid or blocked target: position unchanged, bump=1.
    - Otherwise: position updates to the target, bump=0.
- Evaluation of the new cell after a successful move, in priority order:
  1. Sword cell sets sword=1. Re-entry has no further effect.
  2. Dragon cell with slain=0: if sword=1 (including the edge on which it was picked up, which is impossible because the cells are distinct), slain=1 and play continues. Otherwise go to DEAD with cause=1.
  3. Exit cell: go to WON. Entering the exit requires neither the sword nor a slain dragon.
- Timeout: if the attempt makes moves==MAX_MOVES and the FSM did not reach WON or DEAD by dragon on that edge, go to DEAD with cause=2. Priority is WON > dragon > timeout.
- A dragon entry with slain=1 is harmless.
- In DEAD/WON, all inputs are ignored. Position, flags and moves freeze; bump=0.
- moves never exceeds MAX_MOVES, because the game ends when it is reached.

## Timing
- All outputs are registered and update only on the rising clk edge.
- Response to the requests sampled at edge k is visible immediately after edge k. This gives 1-edge latency, matching the bench's drive-then-@(posedge clk) pattern.
- d and win are asserted after the same edge that moved into the fatal/exit cell or exhausted the budget. Both stay high until reset; they are never both 1.
- Reset, held for any duration and applied in any state (including mid-game or in DEAD/WON), drives the following on the next edge:
  - row=START_R, col=START_C
  - d=0, win=0, cause=0, sword=0, slain=0, bump=0, moves=0
  - FSM=PLAY
- Reset has priority over all inputs on that edge. Direction inputs are ignored while reset=1.
- No combinational path from inputs to outputs.

## Test plan
All scenarios use default parameters and apply reset between them.
- Reset: assert reset 50 ns, release → row=0, col=0, moves=0, d=win=sword=slain=bump=0, cause=0.
- Edge and wall bump: "N" at (0,0) → bump=1, (0,0), moves=1. Then "E","S" → (1,1), moves=3. Then "E" into blocked cell 6 → bump=1, stays (1,1), moves=4. Simultaneous n+e → bump=1, moves stays 4.
- Dragon death: "SSEE" → after 4th edge (2,2), d=1, cause=1, win=0. Further "S" → row/col/moves frozen at (2,2)/4.
- Full win: "SSS" → (3,0), sword=1. Then "NEE" → (2,2), slain=1, d=0. Then "SE" → (3,3), win=1, moves=8, cause=0.
- Timeout: 20 consecutive "N" at (0,0) → after 19th edge d=0, moves=19. After 20th edge d=1, cause=2, moves=20.
- Reset mid-game: "SS" then reset for one edge → (0,0), moves=0, sword=0. Then "SSS" → sword=1, proving play resumes normally.
